// File: rtl/input_register.sv
// Receive side of the 16-bit I/O path: synchronizes switch data and a bouncy enter button,
// debounces the button and captures one word per press into a read-consumed holding register.
module input_register #(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_pins,
    input  logic             strobe_pin,
    input  logic             inputRead,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             overrun
);

    localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] data_sync;
    logic [1:0]       strobe_ff_reg;
    logic             strobe_sync;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_data_sync
        logic [1:0] sync_reg;
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                sync_reg <= '0;
            end else begin
                sync_reg <= {sync_reg[0], data_pins[gi]};
            end
        end
        assign data_sync[gi] = sync_reg[1];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            strobe_ff_reg <= '0;
        end else begin
            strobe_ff_reg <= {strobe_ff_reg[0], strobe_pin};
        end
    end
    assign strobe_sync = strobe_ff_reg[1];

    // Debouncer: a run of DEBOUNCE_CYCLES mismatching samples flips strobe_db; any match restarts.
    logic          strobe_db;
    logic          strobe_db_next;
    logic          strobe_db_q;
    logic [CW-1:0] db_count_reg;
    logic [CW-1:0] db_count_next;
    logic          press;

    always_comb begin
        strobe_db_next = strobe_db;
        db_count_next  = db_count_reg;
        if (strobe_sync == strobe_db) begin
            db_count_next = '0;
        end else if (db_count_reg == TERM) begin
            strobe_db_next = strobe_sync;
            db_count_next  = '0;
        end else begin
            db_count_next = db_count_reg + CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            strobe_db    <= 1'b0;
            strobe_db_q  <= 1'b0;
            db_count_reg <= '0;
        end else begin
            strobe_db    <= strobe_db_next;
            strobe_db_q  <= strobe_db;
            db_count_reg <= db_count_next;
        end
    end

    assign press = strobe_db & ~strobe_db_q;

    // A press takes priority over a read; a simultaneous read only suppresses the overrun flag.
    logic [WIDTH-1:0] data_out_next;
    logic             data_valid_next;
    logic             overrun_next;

    always_comb begin
        data_out_next   = data_out;
        data_valid_next = data_valid;
        overrun_next    = overrun;
        if (press) begin
            data_out_next   = data_sync;
            data_valid_next = 1'b1;
            overrun_next    = overrun | (data_valid & ~inputRead);
        end else if (inputRead) begin
            data_valid_next = 1'b0;
            overrun_next    = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            data_out   <= data_out_next;
            data_valid <= data_valid_next;
            overrun    <= overrun_next;
        end
    end

endmodule

// File: tb/tb_input_register.sv
// Bench for input_register: a sample-history model checked every cycle, plus directed
// presses, bounces, overrun, read/press collision and reset-mid-debounce scenarios.
module tb_input_register;

    localparam int W = 16;
    localparam int D = 4;

    logic         clock = 1'b0;
    logic         reset_n;
    logic [W-1:0] data_pins;
    logic         strobe_pin;
    logic         inputRead;
    logic [W-1:0] data_out;
    logic         data_valid;
    logic         overrun;

    always #5 clock = ~clock;

    input_register #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .data_pins  (data_pins),
        .strobe_pin (strobe_pin),
        .inputRead  (inputRead),
        .data_out   (data_out),
        .data_valid (data_valid),
        .overrun    (overrun)
    );

    int errors = 0;
    int checks = 0;
    bit run_cmp = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: keeps the raw pin samples of recent edges; what the synchronized strobe saw two
    // edges ago decides debounce (last D synchronized samples all disagreeing flips it).
    typedef struct packed {
        logic         s;
        logic [W-1:0] d;
    } samp_t;

    samp_t        hist[$];
    logic         m_db, m_pend;
    logic [W-1:0] m_out;
    logic         m_valid, m_ovr;
    int           m_caps = 0;
    bit           all_diff;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hist.delete();
            for (int i = 0; i < D + 2; i++) hist.push_back('0);
            m_db = 0; m_pend = 0; m_out = '0; m_valid = 0; m_ovr = 0;
        end else begin
            hist.push_front({strobe_pin, data_pins});
            void'(hist.pop_back());
            if (m_pend) begin
                m_out   = hist[2].d;
                m_ovr   = m_ovr | (m_valid & ~inputRead);
                m_valid = 1'b1;
                m_caps++;
            end else if (inputRead) begin
                m_valid = 1'b0;
                m_ovr   = 1'b0;
            end
            all_diff = 1'b1;
            for (int i = 2; i < D + 2; i++) if (hist[i].s == m_db) all_diff = 1'b0;
            m_pend = all_diff && !m_db;
            if (all_diff) m_db = ~m_db;
        end
    end

    always @(negedge clock) begin
        if (run_cmp) begin
            chk("cmp_data_out", data_out, m_out);
            chk("cmp_data_valid", data_valid, m_valid);
            chk("cmp_overrun", overrun, m_ovr);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic press_word(input logic [W-1:0] v);
        data_pins = v;
        tick(3);
        strobe_pin = 1'b1;
        tick(D + 6);
        strobe_pin = 1'b0;
        tick(D + 6);
    endtask

    task automatic read_pulse();
        inputRead = 1'b1;
        tick(1);
        inputRead = 1'b0;
    endtask

    int c0;

    initial begin
        reset_n = 1'b1; data_pins = '0; strobe_pin = 1'b0; inputRead = 1'b0;
        #3 reset_n = 1'b0;
        #1;
        chk("t1_reset_out", data_out, 16'h0000);
        chk("t1_reset_valid", data_valid, 1'b0);
        chk("t1_reset_ovr", overrun, 1'b0);
        tick(2);
        reset_n = 1'b1;
        run_cmp = 1'b1;

        // 1: idle with strobe low
        tick(100);
        chk("t1_idle_valid", data_valid, 1'b0);
        chk("t1_idle_out", data_out, 16'h0000);

        // 2: clean press, capture after edge 6
        data_pins = 16'hBEEF;
        tick(3);
        strobe_pin = 1'b1;
        tick(6);
        chk("t2_valid_edge5", data_valid, 1'b0);
        tick(1);
        chk("t2_valid_edge6", data_valid, 1'b1);
        chk("t2_out_edge6", data_out, 16'hBEEF);
        tick(4);
        read_pulse();
        chk("t2_read_valid", data_valid, 1'b0);
        chk("t2_read_out", data_out, 16'hBEEF);
        strobe_pin = 1'b0;
        tick(D + 6);

        // 3: bouncy press then bouncy release
        c0 = m_caps;
        data_pins = 16'h5A5A;
        tick(3);
        strobe_pin = 1'b1; tick(2);
        strobe_pin = 1'b0; tick(2);
        strobe_pin = 1'b1; tick(2);
        strobe_pin = 1'b0; tick(2);
        strobe_pin = 1'b1;
        tick(6);
        chk("t3_valid_edge5", data_valid, 1'b0);
        tick(1);
        chk("t3_valid_edge6", data_valid, 1'b1);
        chk("t3_out", data_out, 16'h5A5A);
        chk("t3_model_caps", m_caps - c0, 1);
        read_pulse();
        strobe_pin = 1'b0; tick(2);
        strobe_pin = 1'b1; tick(2);
        strobe_pin = 1'b0; tick(2);
        strobe_pin = 1'b1; tick(2);
        strobe_pin = 1'b0; tick(D + 6);
        chk("t3_release_valid", data_valid, 1'b0);
        chk("t3_release_caps", m_caps - c0, 1);

        // 4: overrun
        press_word(16'h0001);
        press_word(16'h0002);
        chk("t4_out", data_out, 16'h0002);
        chk("t4_valid", data_valid, 1'b1);
        chk("t4_ovr", overrun, 1'b1);
        read_pulse();
        chk("t4_read_valid", data_valid, 1'b0);
        chk("t4_read_ovr", overrun, 1'b0);
        chk("t4_read_out", data_out, 16'h0002);

        // 5: read on the capture edge of a new word while one is unread
        press_word(16'h0ABC);
        data_pins = 16'h1234;
        tick(3);
        strobe_pin = 1'b1;
        tick(6);
        inputRead = 1'b1;
        tick(1);
        inputRead = 1'b0;
        chk("t5_out", data_out, 16'h1234);
        chk("t5_valid", data_valid, 1'b1);
        chk("t5_ovr", overrun, 1'b0);
        strobe_pin = 1'b0;
        tick(D + 6);

        // 6: reset mid-debounce, button still held at release
        data_pins = 16'hC0DE;
        tick(3);
        strobe_pin = 1'b1;
        tick(2);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_async_out", data_out, 16'h0000);
        chk("t6_async_valid", data_valid, 1'b0);
        chk("t6_async_ovr", overrun, 1'b0);
        tick(2);
        reset_n = 1'b1;
        c0 = m_caps;
        tick(6);
        chk("t6_valid_edge5", data_valid, 1'b0);
        tick(1);
        chk("t6_valid_edge6", data_valid, 1'b1);
        chk("t6_out", data_out, 16'hC0DE);
        strobe_pin = 1'b0;
        tick(D + 6);
        chk("t6_caps", m_caps - c0, 1);
        chk("t6_hold_valid", data_valid, 1'b1);

        run_cmp = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
